// File: rtl/poly_mau_ctrl_pkg.sv
// Shared definitions for the MAU operand sequencer: FSM encodings, ALU mode codes
// and the default drain watchdog limit.
package poly_mau_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [3:0] ALU_PADD = 4'd0;
    localparam logic [3:0] ALU_PSUB = 4'd1;
    localparam logic [3:0] ALU_PMUL = 4'd2;
    localparam logic [3:0] ALU_PMAC = 4'd3;

    localparam int TO_CYC_DEFAULT = 64;

    // Results are only accepted while a command is in flight.
    function automatic logic is_capture_state(input state_t s);
        return (s == ST_ISSUE) || (s == ST_DRAIN);
    endfunction

endpackage

// File: rtl/poly_mau_ctrl_wb.sv
// Result write-back: counts MAU results, forms destination addresses and
// registers the write strobe, address and data for the destination RAM.
module poly_mau_ctrl_wb
    import poly_mau_ctrl_pkg::*;
#(
    parameter int AW = 8,
    parameter int DW = 24
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clear,
    input  logic          capture_en,
    input  logic          mau_valid,
    input  logic [DW-1:0] mau_o0,
    input  logic [AW-1:0] dst,
    output logic [AW:0]   rc,
    output logic          wr_en,
    output logic [AW-1:0] wr_addr,
    output logic [DW-1:0] wr_data
);

    logic [AW:0]   rc_reg;
    logic          wr_en_reg;
    logic [AW-1:0] wr_addr_reg;
    logic [DW-1:0] wr_data_reg;
    logic          capture;

    assign capture = capture_en && mau_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            rc_reg      <= '0;
            wr_en_reg   <= 1'b0;
            wr_addr_reg <= '0;
            wr_data_reg <= '0;
        end else begin
            wr_en_reg <= capture;
            if (clear) begin
                rc_reg <= '0;
            end else if (capture) begin
                rc_reg      <= rc_reg + 1'b1;
                // Address wraps modulo the RAM depth.
                wr_addr_reg <= dst + rc_reg[AW-1:0];
                wr_data_reg <= mau_o0;
            end
        end
    end

    assign rc      = rc_reg;
    assign wr_en   = wr_en_reg;
    assign wr_addr = wr_addr_reg;
    assign wr_data = wr_data_reg;

endmodule

// File: rtl/poly_mau_ctrl.sv
// Command-driven operand sequencer and result collector for the polynomial MAU.
// Optional drain watchdog enabled by defining POLY_MAU_CTRL_TIMEOUT_EN.
module poly_mau_ctrl
    import poly_mau_ctrl_pkg::*;
#(
    parameter int AW     = 8,
    parameter int DW     = 24,
    parameter int TO_CYC = TO_CYC_DEFAULT
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [3:0]    cmd_alu_mode,
    input  logic [AW:0]   cmd_len,
    input  logic [AW-1:0] cmd_src_a,
    input  logic [AW-1:0] cmd_src_b,
    input  logic [AW-1:0] cmd_dst,
    output logic          rd_en,
    output logic [AW-1:0] rd_addr_a,
    output logic [AW-1:0] rd_addr_b,
    input  logic [DW-1:0] rd_data_a,
    input  logic [DW-1:0] rd_data_b,
    output logic          mau_enable,
    output logic [3:0]    mau_alu_mode,
    output logic [DW-1:0] mau_a,
    output logic [DW-1:0] mau_b,
    input  logic          mau_valid,
    input  logic [DW-1:0] mau_o0,
    output logic          wr_en,
    output logic [AW-1:0] wr_addr,
    output logic [DW-1:0] wr_data,
    output logic          busy,
    output logic          done,
    output logic          err
);

    localparam logic [AW:0] LEN_ONE = (AW+1)'(1);

    state_t        state_reg, state_next;
    logic [AW:0]   ic_reg;
    logic [AW:0]   len_reg;
    logic [AW-1:0] src_a_reg, src_b_reg, dst_reg;
    logic [3:0]    mode_reg;
    logic          mau_enable_reg;
    logic [AW:0]   rc;
    logic [AW:0]   last_idx;
    logic          accept;
    logic          timeout_hit;

    assign accept    = cmd_valid && (state_reg == ST_IDLE);
    assign last_idx  = len_reg - LEN_ONE;
    assign cmd_ready = (state_reg == ST_IDLE);
    assign busy      = (state_reg != ST_IDLE);
    assign done      = (state_reg == ST_DONE);
    assign rd_en     = (state_reg == ST_ISSUE);
    assign rd_addr_a = src_a_reg + ic_reg[AW-1:0];
    assign rd_addr_b = src_b_reg + ic_reg[AW-1:0];

    // RAM read latency is one cycle, so a one-cycle delayed strobe lines up
    // with the data passed straight through to the MAU.
    assign mau_enable   = mau_enable_reg;
    assign mau_alu_mode = mode_reg;
    assign mau_a        = rd_data_a;
    assign mau_b        = rd_data_b;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        unique case (state_reg)
            ST_IDLE: begin
                if (accept) begin
                    state_next = (cmd_len == '0) ? ST_DONE : ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (ic_reg == last_idx) begin
                    state_next = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (mau_valid && (rc == last_idx)) begin
                    state_next = ST_DONE;
                end else if (timeout_hit) begin
                    state_next = ST_IDLE;
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ic_reg         <= '0;
            len_reg        <= '0;
            src_a_reg      <= '0;
            src_b_reg      <= '0;
            dst_reg        <= '0;
            mode_reg       <= '0;
            mau_enable_reg <= 1'b0;
        end else begin
            mau_enable_reg <= rd_en;
            if (accept) begin
                ic_reg    <= '0;
                len_reg   <= cmd_len;
                src_a_reg <= cmd_src_a;
                src_b_reg <= cmd_src_b;
                dst_reg   <= cmd_dst;
                mode_reg  <= cmd_alu_mode;
            end else if (state_reg == ST_ISSUE) begin
                ic_reg <= ic_reg + LEN_ONE;
            end
        end
    end

    poly_mau_ctrl_wb #(
        .AW(AW),
        .DW(DW)
    ) u_wb (
        .clk        (clk),
        .rst        (rst),
        .clear      (accept),
        .capture_en (is_capture_state(state_reg)),
        .mau_valid  (mau_valid),
        .mau_o0     (mau_o0),
        .dst        (dst_reg),
        .rc         (rc),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data)
    );

`ifdef POLY_MAU_CTRL_TIMEOUT_EN
    localparam int TO_W = $clog2(TO_CYC + 1);

    logic [TO_W-1:0] to_cnt_reg;
    logic            err_reg;

    // Counter sits at zero outside DRAIN, so entering DRAIN starts a fresh window.
    assign timeout_hit = (state_reg == ST_DRAIN) && !mau_valid
                         && (to_cnt_reg == TO_W'(TO_CYC - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            to_cnt_reg <= '0;
            err_reg    <= 1'b0;
        end else begin
            err_reg <= timeout_hit;
            if ((state_reg != ST_DRAIN) || mau_valid) begin
                to_cnt_reg <= '0;
            end else begin
                to_cnt_reg <= to_cnt_reg + 1'b1;
            end
        end
    end

    assign err = err_reg;
`else
    assign timeout_hit = 1'b0;
    assign err         = 1'b0;
`endif

endmodule
